// File: rtl/dmem_store_arbiter.sv
// Single Dmem port owner: in-order retired-store queue drained in the background, one outstanding load.
// Optional store-to-load forwarding of exact WORD matches under `DMEM_STORE_FWD_EN.

module dmem_sq_match #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] entry_addr,
  input  logic [XLEN-1:0] ld_addr,
  output logic            word_hit
);
  assign word_hit = entry_addr[XLEN-1:2] == ld_addr[XLEN-1:2];
endmodule

module dmem_store_arbiter #(
  parameter int SQ_DEPTH = 4,
  parameter int XLEN     = 32
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      st_valid,
  input  logic [1:0]                st_size,
  input  logic [XLEN-1:0]           st_addr,
  input  logic [XLEN-1:0]           st_data,
  output logic                      st_full,
  output logic [$clog2(SQ_DEPTH):0] sq_count,
  input  logic                      ld_req,
  input  logic [XLEN-1:0]           ld_addr,
  input  logic [1:0]                ld_size,
  output logic                      ld_grant,
  output logic                      ld_done,
  output logic [XLEN-1:0]           ld_data,
  output logic [1:0]                proc2Dmem_command,
  output logic [XLEN-1:0]           proc2Dmem_addr,
  output logic [63:0]               proc2Dmem_data,
  output logic [1:0]                proc2Dmem_size,
  input  logic [3:0]                mem2proc_response,
  input  logic [3:0]                mem2proc_tag,
  input  logic [63:0]               mem2proc_data
);
  localparam int PW = $clog2(SQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;
  localparam logic [1:0] MEM_WORD  = 2'd2;

  typedef enum logic {IDLE, LD_WAIT} ld_state_t;

  ld_state_t                       state;
  logic [3:0]                      tag_q;
  logic                            half_q;
  logic [PW-1:0]                   head, tail;
  logic [CW-1:0]                   count;
  logic [SQ_DEPTH-1:0][XLEN-1:0]   q_addr;
  logic [SQ_DEPTH-1:0][XLEN-1:0]   q_data;
  logic [SQ_DEPTH-1:0][1:0]        q_size;
  logic [SQ_DEPTH-1:0]             hit;
  logic                            blocked, fwd_hit, tag_hit;
  logic                            empty, load_sel, store_sel, accepted, enq, deq;
  logic [PW-1:0]                   idx;
`ifdef DMEM_STORE_FWD_EN
  logic [PW-1:0]                   young;
`endif

  for (genvar g = 0; g < SQ_DEPTH; g++) begin : g_match
    dmem_sq_match #(.XLEN(XLEN)) u_match (
      .entry_addr (q_addr[g]),
      .ld_addr    (ld_addr),
      .word_hit   (hit[g])
    );
  end

  // Walk occupied slots oldest to youngest; the last hit is the youngest match.
  always_comb begin
    blocked = 1'b0;
    idx     = head;
`ifdef DMEM_STORE_FWD_EN
    young   = head;
`endif
    for (int k = 0; k < SQ_DEPTH; k++) begin
      idx = head + PW'(k);
      if (k < int'(count) && hit[idx]) begin
        blocked = 1'b1;
`ifdef DMEM_STORE_FWD_EN
        young   = idx;
`endif
      end
    end
  end

`ifdef DMEM_STORE_FWD_EN
  assign fwd_hit = (state == IDLE) && ld_req && blocked && (q_addr[young] == ld_addr) &&
                   (q_size[young] == ld_size) && (ld_size == MEM_WORD);
`else
  assign fwd_hit = 1'b0;
`endif

  assign sq_count  = count;
  assign st_full   = count == CW'(SQ_DEPTH);
  assign empty     = count == '0;
  assign accepted  = mem2proc_response != 4'd0;
  assign load_sel  = !st_full && (state == IDLE) && ld_req && !blocked;
  assign store_sel = !load_sel && !empty;
  assign deq       = store_sel && accepted;
  assign enq       = st_valid && !st_full;
  assign ld_grant  = load_sel && accepted;
  assign tag_hit   = (state == LD_WAIT) && (mem2proc_tag != 4'd0) && (mem2proc_tag == tag_q);
  assign ld_done   = tag_hit || fwd_hit;

  always_comb begin
    ld_data = '0;
    if (tag_hit)
      ld_data = half_q ? mem2proc_data[63:32] : mem2proc_data[31:0];
`ifdef DMEM_STORE_FWD_EN
    else if (fwd_hit)
      ld_data = q_data[young];
`endif
  end

  always_comb begin
    proc2Dmem_command = BUS_NONE;
    proc2Dmem_addr    = '0;
    proc2Dmem_data    = '0;
    proc2Dmem_size    = '0;
    if (load_sel) begin
      proc2Dmem_command = BUS_LOAD;
      proc2Dmem_addr    = ld_addr;
      proc2Dmem_size    = ld_size;
    end else if (store_sel) begin
      proc2Dmem_command = BUS_STORE;
      proc2Dmem_addr    = q_addr[head];
      proc2Dmem_size    = q_size[head];
      proc2Dmem_data    = q_addr[head][2] ? {q_data[head], 32'h0} : {32'h0, q_data[head]};
    end
  end

  // Payload storage carries no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (enq) begin
      q_addr[tail] <= st_addr;
      q_data[tail] <= st_data;
      q_size[tail] <= st_size;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      state  <= IDLE;
      tag_q  <= '0;
      half_q <= 1'b0;
    end else begin
      if (enq) tail <= tail + PW'(1);
      if (deq) head <= head + PW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      case (state)
        IDLE: if (ld_grant) begin
          state  <= LD_WAIT;
          tag_q  <= mem2proc_response;
          half_q <= ld_addr[2];
        end
        LD_WAIT: if (tag_hit) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_store_arbiter.sv
// Directed scenarios followed by a randomized run checked against a queue-based reference model.
module tb_dmem_store_arbiter;
  localparam int D = 4;
  localparam logic [1:0] BN = 2'd0, BL = 2'd1, BS = 2'd2, SW = 2'd2;

  logic        clock = 1'b0, reset_n = 1'b0;
  logic        st_valid, st_full, ld_req, ld_grant, ld_done;
  logic [1:0]  st_size, ld_size, proc2Dmem_command, proc2Dmem_size;
  logic [31:0] st_addr, st_data, ld_addr, ld_data, proc2Dmem_addr;
  logic [2:0]  sq_count;
  logic [63:0] proc2Dmem_data, mdata;
  logic [3:0]  resp, mtag;

  int total = 0, bad = 0;

  typedef struct {logic [31:0] a; logic [1:0] s; logic [31:0] d;} st_t;
  st_t mq[$];

  dmem_store_arbiter #(.SQ_DEPTH(D), .XLEN(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .st_valid(st_valid), .st_size(st_size), .st_addr(st_addr), .st_data(st_data),
    .st_full(st_full), .sq_count(sq_count),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_size(ld_size),
    .ld_grant(ld_grant), .ld_done(ld_done), .ld_data(ld_data),
    .proc2Dmem_command(proc2Dmem_command), .proc2Dmem_addr(proc2Dmem_addr),
    .proc2Dmem_data(proc2Dmem_data), .proc2Dmem_size(proc2Dmem_size),
    .mem2proc_response(resp), .mem2proc_tag(mtag), .mem2proc_data(mdata)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic put_store(input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1; st_size = SW; st_addr = a; st_data = d;
  endtask

  initial begin
    logic [31:0] e32, ra;
    logic [1:0]  rs;
    logic [3:0]  tagm;
    bit          req, busy, halfm, fullm, blk, fwd, lsel, ssel, gr, tdone;
    int          yi;
    logic [1:0]  ecmd, esize;
    logic [31:0] eaddr, eld;
    logic [63:0] edata;

    st_valid = 0; st_size = 0; st_addr = 0; st_data = 0;
    ld_req = 0; ld_addr = 0; ld_size = 0; resp = 0; mtag = 0; mdata = 0;

    // Reset values
    @(negedge clock);
    chk("rst_cmd",   64'(proc2Dmem_command), 64'(BN));
    chk("rst_addr",  64'(proc2Dmem_addr), 64'd0);
    chk("rst_data",  proc2Dmem_data, 64'd0);
    chk("rst_size",  64'(proc2Dmem_size), 64'd0);
    chk("rst_full",  64'(st_full), 64'd0);
    chk("rst_count", 64'(sq_count), 64'd0);
    chk("rst_grant", 64'(ld_grant), 64'd0);
    chk("rst_done",  64'(ld_done), 64'd0);
    chk("rst_lddata", 64'(ld_data), 64'd0);
    @(posedge clock); #1 reset_n = 1'b1;

    // Fill with memory rejecting, then drain in order
    for (int i = 0; i < 4; i++) begin
      put_store(32'h100 + 32'(i * 4), 32'hA0 + 32'(i));
      if (i == 1) begin
        @(negedge clock);
        chk("enq_lat_count", 64'(sq_count), 64'd1);
        chk("enq_lat_cmd",   64'(proc2Dmem_command), 64'(BS));
        chk("enq_lat_addr",  64'(proc2Dmem_addr), 64'h100);
      end
      step();
    end
    put_store(32'h1F0, 32'hDEAD);
    @(negedge clock);
    chk("fill_full",  64'(st_full), 64'd1);
    chk("fill_count", 64'(sq_count), 64'd4);
    step();
    st_valid = 1'b0;
    resp = 4'd1;
    for (int i = 0; i < 4; i++) begin
      e32 = 32'hA0 + 32'(i);
      @(negedge clock);
      chk("drain_cmd",   64'(proc2Dmem_command), 64'(BS));
      chk("drain_addr",  64'(proc2Dmem_addr), 64'(32'h100 + 32'(i * 4)));
      chk("drain_data",  proc2Dmem_data, (i % 2 == 1) ? {e32, 32'h0} : {32'h0, e32});
      chk("drain_count", 64'(sq_count), 64'(4 - i));
      step();
    end
    resp = 4'd0;
    @(negedge clock);
    chk("drain_empty", 64'(sq_count), 64'd0);
    chk("drain_none",  64'(proc2Dmem_command), 64'(BN));
    step();

    // Reset mid-drain with a load outstanding
    for (int i = 0; i < 3; i++) begin
      put_store(32'h400 + 32'(i * 8), 32'h40 + 32'(i));
      step();
    end
    st_valid = 1'b0;
    ld_req = 1'b1; ld_addr = 32'h500; ld_size = SW; resp = 4'd5;
    @(negedge clock);
    chk("rst_mid_grant", 64'(ld_grant), 64'd1);
    step();
    ld_req = 1'b0; resp = 4'd1;
    @(negedge clock);
    chk("rst_mid_cmd", 64'(proc2Dmem_command), 64'(BS));
    reset_n = 1'b0;
    #1;
    chk("rst_mid_count", 64'(sq_count), 64'd0);
    chk("rst_mid_none",  64'(proc2Dmem_command), 64'(BN));
    step();
    reset_n = 1'b1; resp = 4'd0; mtag = 4'd5; mdata = 64'h5555_6666_7777_8888;
    @(negedge clock);
    chk("rst_late_tag", 64'(ld_done), 64'd0);
    step();
    mtag = 4'd0;

    // Load beats a non-full queue
    put_store(32'h180, 32'h77);
    step();
    st_valid = 1'b0;
    ld_req = 1'b1; ld_addr = 32'h200; ld_size = SW; resp = 4'd2;
    @(negedge clock);
    chk("prio_cmd",   64'(proc2Dmem_command), 64'(BL));
    chk("prio_addr",  64'(proc2Dmem_addr), 64'h200);
    chk("prio_grant", 64'(ld_grant), 64'd1);
    step();
    ld_req = 1'b0; resp = 4'd1;
    @(negedge clock);
    chk("prio_st_cmd",  64'(proc2Dmem_command), 64'(BS));
    chk("prio_st_addr", 64'(proc2Dmem_addr), 64'h180);
    chk("prio_nodone",  64'(ld_done), 64'd0);
    step();
    resp = 4'd0; mtag = 4'd2; mdata = 64'hAAAA_BBBB_CCCC_DDDD;
    @(negedge clock);
    chk("prio_done",   64'(ld_done), 64'd1);
    chk("prio_lddata", 64'(ld_data), 64'hCCCCDDDD);
    step();
    mtag = 4'd0;
    @(negedge clock);
    chk("prio_done_pulse", 64'(ld_done), 64'd0);
    step();

    // Full queue overrides a pending load
    for (int i = 0; i < 4; i++) begin
      put_store(32'h600 + 32'(i * 4), 32'h60 + 32'(i));
      step();
    end
    st_valid = 1'b0;
    ld_req = 1'b1; ld_addr = 32'h704; ld_size = SW; resp = 4'd3;
    @(negedge clock);
    chk("full_cmd",   64'(proc2Dmem_command), 64'(BS));
    chk("full_addr",  64'(proc2Dmem_addr), 64'h600);
    chk("full_grant", 64'(ld_grant), 64'd0);
    step();
    @(negedge clock);
    chk("full_ld_cmd",   64'(proc2Dmem_command), 64'(BL));
    chk("full_ld_grant", 64'(ld_grant), 64'd1);
    step();
    ld_req = 1'b0; resp = 4'd1; mtag = 4'd3; mdata = 64'h1111_2222_3333_4444;
    @(negedge clock);
    chk("full_done",   64'(ld_done), 64'd1);
    chk("full_lddata", 64'(ld_data), 64'h11112222);
    step();
    mtag = 4'd0;
    step();
    step();
    resp = 4'd0;
    @(negedge clock);
    chk("full_empty", 64'(sq_count), 64'd0);
    step();

    // Address hazard
    put_store(32'h300, 32'h1234);
    step();
    st_valid = 1'b0;
    ld_req = 1'b1; ld_addr = 32'h300; ld_size = SW; resp = 4'd0;
    @(negedge clock);
`ifdef DMEM_STORE_FWD_EN
    chk("haz_fwd_done",  64'(ld_done), 64'd1);
    chk("haz_fwd_data",  64'(ld_data), 64'h1234);
    chk("haz_fwd_cmd",   64'(proc2Dmem_command), 64'(BS));
    chk("haz_fwd_grant", 64'(ld_grant), 64'd0);
    step();
    ld_req = 1'b0; resp = 4'd1;
    @(negedge clock);
    chk("haz_fwd_drain", 64'(proc2Dmem_addr), 64'h300);
    step();
    resp = 4'd0;
`else
    chk("haz_grant0", 64'(ld_grant), 64'd0);
    chk("haz_cmd0",   64'(proc2Dmem_command), 64'(BS));
    chk("haz_done0",  64'(ld_done), 64'd0);
    step();
    resp = 4'd4;
    @(negedge clock);
    chk("haz_st_first", 64'(proc2Dmem_command), 64'(BS));
    chk("haz_grant1",   64'(ld_grant), 64'd0);
    step();
    @(negedge clock);
    chk("haz_ld_cmd",   64'(proc2Dmem_command), 64'(BL));
    chk("haz_ld_grant", 64'(ld_grant), 64'd1);
    step();
    ld_req = 1'b0; resp = 4'd0; mtag = 4'd4; mdata = 64'h0000_9999_0000_1234;
    @(negedge clock);
    chk("haz_done", 64'(ld_done), 64'd1);
    chk("haz_data", 64'(ld_data), 64'h1234);
    step();
    mtag = 4'd0;
`endif

    // Wrap with simultaneous enqueue/dequeue
    resp = 4'd1;
    for (int i = 0; i < 10; i++) begin
      put_store(32'h800 + 32'(i * 8), 32'hC00 + 32'(i));
      @(negedge clock);
      chk("wrap_count", 64'(sq_count), (i == 0) ? 64'd0 : 64'd1);
      if (i > 0) chk("wrap_addr", 64'(proc2Dmem_addr), 64'(32'h800 + 32'((i - 1) * 8)));
      step();
    end
    st_valid = 1'b0;
    @(negedge clock);
    chk("wrap_last", 64'(proc2Dmem_addr), 64'(32'h800 + 32'd72));
    step();
    resp = 4'd0;
    @(negedge clock);
    chk("wrap_empty", 64'(sq_count), 64'd0);

    // Randomized run against the reference model
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    mq.delete();
    req = 0; busy = 0; halfm = 0; tagm = 0; ra = 0; rs = 0;
    for (int n = 0; n < 1500; n++) begin
      if (!req && !busy && $urandom_range(0, 2) == 0) begin
        req = 1;
        ra  = 32'h1000 + 32'($urandom_range(0, 5) * 4) + (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
        rs  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 1)) : SW;
      end
      ld_req = req; ld_addr = ra; ld_size = rs;
      fullm = (mq.size() == D);
      st_valid = !fullm && ($urandom_range(0, 1) == 1);
      st_addr  = 32'h1000 + 32'($urandom_range(0, 5) * 4) + (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
      st_size  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 1)) : SW;
      st_data  = $urandom;
      resp     = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      if (busy && $urandom_range(0, 2) == 0) mtag = tagm;
      else begin
        mtag = 4'($urandom_range(0, 15));
        if (busy && mtag == tagm) mtag = 4'd0;
      end
      mdata = {$urandom, $urandom};

      blk = 0; yi = -1;
      for (int k = 0; k < mq.size(); k++)
        if (mq[k].a[31:2] == ra[31:2]) begin blk = 1; yi = k; end
      fwd = 0;
`ifdef DMEM_STORE_FWD_EN
      if (req && !busy && blk && mq[yi].a == ra && mq[yi].s == rs && rs == SW) fwd = 1;
`endif
      lsel  = req && !busy && !fullm && !blk;
      ssel  = !lsel && (mq.size() > 0);
      gr    = lsel && (resp != 4'd0);
      tdone = busy && (mtag != 4'd0) && (mtag == tagm);
      ecmd = BN; eaddr = 0; esize = 0; edata = 0; eld = 0;
      if (lsel) begin
        ecmd = BL; eaddr = ra; esize = rs;
      end else if (ssel) begin
        ecmd = BS; eaddr = mq[0].a; esize = mq[0].s;
        edata = mq[0].a[2] ? {mq[0].d, 32'h0} : {32'h0, mq[0].d};
      end
      if (tdone) eld = halfm ? mdata[63:32] : mdata[31:0];
      else if (fwd) eld = mq[yi].d;

      @(negedge clock);
      chk("rnd_cmd",   64'(proc2Dmem_command), 64'(ecmd));
      chk("rnd_addr",  64'(proc2Dmem_addr), 64'(eaddr));
      chk("rnd_data",  proc2Dmem_data, edata);
      chk("rnd_size",  64'(proc2Dmem_size), 64'(esize));
      chk("rnd_grant", 64'(ld_grant), 64'(gr));
      chk("rnd_done",  64'(ld_done), 64'(tdone || fwd));
      if (tdone || fwd) chk("rnd_lddata", 64'(ld_data), 64'(eld));
      chk("rnd_count", 64'(sq_count), 64'(mq.size()));
      chk("rnd_full",  64'(st_full), 64'(fullm));
      step();

      if (ssel && resp != 4'd0) void'(mq.pop_front());
      if (st_valid && !fullm) mq.push_back('{st_addr, st_size, st_data});
      if (gr) begin busy = 1; tagm = resp; halfm = ra[2]; req = 0; end
      if (tdone) busy = 0;
      if (fwd) req = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
